// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared decode types and constants for the dual-issue core
package riscv_pkg;

  // Default issue width and datapath width
  localparam int LANES_DEF = 2;
  localparam int XLEN_DEF  = 32;

  // Major opcodes (inst[6:2])
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  // One decoded lane as handed from decode to execute (pc is the MSB field)
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  op_code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        imm_unsigned;
  } dec_lane_t;

  localparam int DEC_LANE_W = $bits(dec_lane_t);

  // Bits of a lane that are not pc/imm; these do not scale with XLEN
  localparam int CTRL_W = DEC_LANE_W - 2 * XLEN_DEF;

  // Encoding equals the number of held bundles so occupancy is the state itself
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  function automatic logic [1:0] state_occupancy(input skid_state_t s);
    logic [1:0] occ;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/lane_bundle_reg.sv
// rtl/lane_bundle_reg.sv - one bundle-wide register slot with load and lane-valid clear
module lane_bundle_reg #(
  parameter int LANES  = 2,
  parameter int LANE_W = 89
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr_v,
  input  logic                      i_load,
  input  logic [LANES-1:0]          i_lane_v,
  input  logic [LANES*LANE_W-1:0]   i_lane,
  output logic [LANES-1:0]          o_lane_v,
  output logic [LANES*LANE_W-1:0]   o_lane
);

  logic [LANES-1:0]        r_lane_v;
  logic [LANES*LANE_W-1:0] r_lane;

  // Clearing only drops lane valids; the payload keeps stale bits that are masked downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_v <= '0;
      r_lane   <= '0;
    end else if (i_clr_v) begin
      r_lane_v <= '0;
    end else if (i_load) begin
      r_lane_v <= i_lane_v;
      r_lane   <= i_lane;
    end
  end

  assign o_lane_v = r_lane_v;
  assign o_lane   = r_lane;

endmodule

// File: rtl/id_ex_skid_buffer.sv
// rtl/id_ex_skid_buffer.sv - decode-to-execute two-entry skid buffer with flush and stall counter
module id_ex_skid_buffer
  import riscv_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES-1:0]                      in_lane_v,
  input  logic [LANES*(2*XLEN+CTRL_W)-1:0]      in_lane,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES-1:0]                      out_lane_v,
  output logic [LANES*(2*XLEN+CTRL_W)-1:0]      out_lane,
  output logic [1:0]                            occupancy,
  output logic [CNT_W-1:0]                      stall_cnt
);

  localparam int LANE_W   = 2 * XLEN + CTRL_W;
  localparam int BUNDLE_W = LANES * LANE_W;

  skid_state_t           r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic                  w_in_take;
  logic                  w_out_fire;
  logic                  w_main_load;
  logic                  w_main_from_skid;
  logic                  w_main_clr;
  logic                  w_skid_load;
  logic                  w_skid_clr;
  logic [LANES-1:0]      w_main_d_v;
  logic [BUNDLE_W-1:0]   w_main_d;
  logic [LANES-1:0]      w_main_q_v;
  logic [BUNDLE_W-1:0]   w_main_q;
  logic [LANES-1:0]      w_skid_q_v;
  logic [BUNDLE_W-1:0]   w_skid_q;

  // A bubble (no lane valid) is accepted on the handshake but never stored
  assign w_in_take  = in_valid && r_in_ready && (|in_lane_v);
  assign w_out_fire = r_out_valid && out_ready;

  // Slot load/clear decode from the current state and both handshakes
  always_comb begin
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (flush) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          w_main_load = w_in_take;
        end
        ST_ONE: begin
          if (w_in_take && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_out_fire) begin
            w_main_clr = 1'b1;
          end else if (w_in_take) begin
            w_skid_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign w_main_d_v = w_main_from_skid ? w_skid_q_v : in_lane_v;
  assign w_main_d   = w_main_from_skid ? w_skid_q   : in_lane;

  lane_bundle_reg #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .i_clr_v  (w_main_clr),
    .i_load   (w_main_load),
    .i_lane_v (w_main_d_v),
    .i_lane   (w_main_d),
    .o_lane_v (w_main_q_v),
    .o_lane   (w_main_q)
  );

  lane_bundle_reg #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_clr_v  (w_skid_clr),
    .i_load   (w_skid_load),
    .i_lane_v (in_lane_v),
    .i_lane   (in_lane),
    .o_lane_v (w_skid_q_v),
    .o_lane   (w_skid_q)
  );

  // Occupancy FSM; in_ready and out_valid are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_take) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_out_fire && !w_in_take) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end else if (!w_out_fire && w_in_take) begin
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where execute holds off a presented bundle; flush does not clear it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_lane_v = w_main_q_v;
  assign out_lane   = w_main_q;
  assign occupancy  = state_occupancy(r_state);
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_skid_buffer.sv
// tb/tb_id_ex_skid_buffer.sv - self-checking bench for id_ex_skid_buffer
module tb_id_ex_skid_buffer;
  import riscv_pkg::*;

  localparam int LANES = 2;
  localparam int LW    = 89;
  localparam int BW    = LANES * LW;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic [LANES-1:0] in_lane_v;
  logic [BW-1:0]    in_lane;
  logic             in_ready, out_valid;
  logic [LANES-1:0] out_lane_v;
  logic [BW-1:0]    out_lane;
  logic [1:0]       occupancy;
  logic [15:0]      stall_cnt;

  logic             s_in_ready, s_out_valid;
  logic [LANES-1:0] s_out_lane_v;
  logic [BW-1:0]    s_out_lane;
  logic [1:0]       s_occupancy;
  logic [3:0]       s_stall_cnt;

  always #5 clk = ~clk;

  id_ex_skid_buffer #(.LANES(2), .XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_v(in_lane_v), .in_lane(in_lane), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_v(out_lane_v), .out_lane(out_lane), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  id_ex_skid_buffer #(.LANES(2), .XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_lane_v(in_lane_v), .in_lane(in_lane), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_lane_v(s_out_lane_v), .out_lane(s_out_lane), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic [LANES-1:0] v;
    logic [BW-1:0]    d;
  } bundle_t;

  typedef struct {
    logic        r, f, iv;
    logic [1:0]  lv;
    logic [31:0] pc;
    logic        ordy;
    logic [1:0]  e_occ;
    logic        e_irdy, e_ov;
    logic [15:0] e_st;
  } vec_t;

  bundle_t     sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_stall = '0;
  logic [3:0]  m_stall4 = '0;
  vec_t        tbl[20];

  function automatic dec_lane_t mk_lane(input logic [31:0] pc, input int ln);
    dec_lane_t l;
    l.pc           = pc + 32'(ln * 4);
    l.imm          = (ln == 0) ? 32'hFFFF_F800 : (pc ^ 32'h0F0F_0F0F);
    l.op_code      = (ln == 0) ? OP_IMM : OP_LOAD;
    l.rd           = pc[7:3];
    l.rs1          = pc[8:4] ^ 5'd3;
    l.rs2          = 5'(ln + 1);
    l.funct3       = pc[5:3];
    l.funct7_b5    = pc[3];
    l.imm_unsigned = (ln != 0);
    return l;
  endfunction

  function automatic logic [BW-1:0] mk_bundle(input logic [31:0] pc);
    return {mk_lane(pc, 1), mk_lane(pc, 0)};
  endfunction

  function automatic vec_t mkv(input logic r, input logic f, input logic iv, input logic [1:0] lv,
                               input logic [31:0] pc, input logic ordy, input logic [1:0] e_occ,
                               input logic e_irdy, input logic e_ov, input logic [15:0] e_st);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.lv = lv; v.pc = pc; v.ordy = ordy;
    v.e_occ = e_occ; v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [1:0] lv,
                       input logic [31:0] pc, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_lane_v = lv;
    in_lane   = mk_bundle(pc);
    out_ready = ordy;
  endtask

  // One clock: compare any bundle leaving, advance the reference queue, then check state
  task automatic tick();
    bundle_t b;
    logic    in_fire;
    if (!rst && sb.size() > 0 && out_ready) begin
      chk("out_lane_v", 256'(out_lane_v), 256'(sb[0].v));
      chk("out_lane", 256'(out_lane), 256'(sb[0].d));
    end
    if (rst) begin
      sb.delete();
      m_stall  = '0;
      m_stall4 = '0;
    end else begin
      if (sb.size() > 0 && !out_ready) begin
        if (m_stall != 16'hFFFF) m_stall++;
        if (m_stall4 != 4'hF) m_stall4++;
      end
      if (flush) begin
        sb.delete();
      end else begin
        in_fire = in_valid && (sb.size() < 2);
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
        if (in_fire && in_lane_v != '0) begin
          b.v = in_lane_v;
          b.d = in_lane;
          sb.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("occupancy", 256'(occupancy), 256'(sb.size()));
    chk("in_ready", 256'(in_ready), 256'(sb.size() < 2));
    chk("out_valid", 256'(out_valid), 256'(sb.size() > 0));
    chk("stall_cnt", 256'(stall_cnt), 256'(m_stall));
    chk("stall_cnt4", 256'(s_stall_cnt), 256'(m_stall4));
    chk("occupancy4", 256'(s_occupancy), 256'(sb.size()));
    if (sb.size() == 0) chk("empty lane_v", 256'(out_lane_v), 256'(0));
  endtask

  initial begin
    // rst f  iv lv     pc            ordy occ irdy ov stall
    tbl[0]  = mkv(1, 0, 0, 2'b00, 32'h0,   0, 0, 1, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 2'b00, 32'h0,   0, 0, 1, 0, 0);
    tbl[2]  = mkv(0, 0, 0, 2'b00, 32'h0,   1, 0, 1, 0, 0);
    tbl[3]  = mkv(0, 0, 0, 2'b00, 32'h0,   1, 0, 1, 0, 0);
    tbl[4]  = mkv(0, 0, 1, 2'b01, 32'h100, 1, 1, 1, 1, 0);
    tbl[5]  = mkv(0, 0, 0, 2'b00, 32'h0,   1, 0, 1, 0, 0);
    tbl[6]  = mkv(0, 0, 1, 2'b11, 32'h200, 0, 1, 1, 1, 0);
    tbl[7]  = mkv(0, 0, 1, 2'b11, 32'h208, 0, 2, 0, 1, 1);
    tbl[8]  = mkv(0, 0, 1, 2'b11, 32'h210, 0, 2, 0, 1, 2);
    tbl[9]  = mkv(0, 0, 1, 2'b11, 32'h210, 1, 1, 1, 1, 2);
    tbl[10] = mkv(0, 0, 1, 2'b11, 32'h210, 1, 1, 1, 1, 2);
    tbl[11] = mkv(0, 0, 0, 2'b00, 32'h0,   1, 0, 1, 0, 2);
    tbl[12] = mkv(0, 0, 1, 2'b11, 32'h300, 0, 1, 1, 1, 2);
    tbl[13] = mkv(0, 0, 1, 2'b10, 32'h308, 0, 2, 0, 1, 3);
    tbl[14] = mkv(0, 1, 1, 2'b11, 32'h310, 0, 0, 1, 0, 4);
    tbl[15] = mkv(0, 0, 0, 2'b00, 32'h0,   1, 0, 1, 0, 4);
    tbl[16] = mkv(0, 0, 1, 2'b00, 32'h0,   1, 0, 1, 0, 4);
    tbl[17] = mkv(0, 0, 1, 2'b10, 32'h400, 0, 1, 1, 1, 4);
    tbl[18] = mkv(0, 0, 1, 2'b00, 32'h0,   0, 1, 1, 1, 5);
    tbl[19] = mkv(0, 0, 0, 2'b00, 32'h0,   1, 0, 1, 0, 5);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].lv, tbl[i].pc, tbl[i].ordy);
      tick();
      chk($sformatf("vec%0d occupancy", i), 256'(occupancy), 256'(tbl[i].e_occ));
      chk($sformatf("vec%0d in_ready", i), 256'(in_ready), 256'(tbl[i].e_irdy));
      chk($sformatf("vec%0d out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
      chk($sformatf("vec%0d stall_cnt", i), 256'(stall_cnt), 256'(tbl[i].e_st));
      if (i == 1) begin
        chk("reset out_lane", 256'(out_lane), 256'(0));
        chk("reset out_lane_v", 256'(out_lane_v), 256'(0));
      end
    end

    // Hold one bundle under backpressure for 20 cycles: the 4-bit counter pins at 15
    drive(0, 0, 1, 2'b11, 32'h500, 0);
    tick();
    drive(0, 0, 0, 2'b00, 32'h0, 0);
    for (int k = 0; k < 20; k++) tick();
    chk("sat stall_cnt4", 256'(s_stall_cnt), 256'(4'hF));
    chk("sat stall_cnt16", 256'(stall_cnt), 256'(16'd25));
    drive(0, 0, 0, 2'b00, 32'h0, 1);
    tick();

    // Flush while ONE with simultaneous input and output fire: both are discarded
    drive(0, 0, 1, 2'b01, 32'h600, 1);
    tick();
    drive(0, 1, 1, 2'b11, 32'h608, 1);
    tick();
    chk("flush one occupancy", 256'(occupancy), 256'(0));
    chk("flush one out_valid", 256'(out_valid), 256'(0));
    chk("flush one out_lane_v", 256'(out_lane_v), 256'(0));
    drive(0, 0, 0, 2'b00, 32'h0, 1);
    tick();
    chk("post flush out_valid", 256'(out_valid), 256'(0));
    chk("flush keeps stall_cnt", 256'(stall_cnt), 256'(16'd25));

    // Continuous streaming: one bundle per cycle, occupancy pinned at 1
    for (int k = 0; k < 50; k++) begin
      drive(0, 0, 1, 2'b11, 32'h1000 + 32'(k * 8), 1);
      tick();
      chk("stream occupancy", 256'(occupancy), 256'(1));
      chk("stream out_lane_v", 256'(out_lane_v), 256'(2'b11));
    end
    drive(0, 0, 0, 2'b00, 32'h0, 1);
    tick();
    chk("stream drained", 256'(occupancy), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_buffer.md
Name: id_ex_skid_buffer

Overview:
- Decode-to-execute boundary register for the dual-issue core.
- Captures each lane's decoded fields plus the 32-bit immediate from the sign-extender stage and presents them to issue/execute.
- Uses a two-entry skid buffer with valid/ready handshakes on both sides, so a backpressured execute stage never drops a bundle and `in_ready` stays fully registered.
- Supports pipeline flush for branch mispredicts and includes a saturating stall-cycle counter.

Parameters:
- LANES, 2, issue width (bundle lanes).
- XLEN, 32, data/immediate width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all held bundles (mispredict/exception).
- in_valid  input  1  decode offers a bundle.
- in_ready  output  1  buffer can accept; registered, depends only on state.
- in_lane_v  input  LANES  per-lane valid within the offered bundle.
- in_lane  input  LANES*89  per-lane dec_lane_t payload: pc[32], imm[32], op_code[5], rd[5], rs1[5], rs2[5], funct3[3], funct7_b5[1], imm_unsigned[1].
- out_valid  output  1  bundle available to execute.
- out_ready  input  1  execute accepts the bundle.
- out_lane_v  output  LANES  per-lane valid of the presented bundle.
- out_lane  output  LANES*89  presented payload.
- occupancy  output  2  held bundles (0..2).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
- Reset values:
  - Applied on the clk edge with rst=1.
  - in_ready=1, out_valid=0, out_lane_v=0, out_lane=0, occupancy=0, stall_cnt=0, state=EMPTY.
- Transfers:
  - Input fires when in_valid && in_ready at a rising edge.
  - Output fires when out_valid && out_ready.
- Bubble bundles:
  - An input fire with in_lane_v==0 is accepted but not stored.
  - A bubble fire is treated as no input for the state transitions below.
- Storage:
  - Two slots, MAIN and SKID.
  - out_* always reflect MAIN, registered, with zero combinational path from inputs.
- States (occupancy = 0/1/2):
  - EMPTY: in_ready=1, out_valid=0. Input fire loads MAIN on the next cycle -> ONE. Latency is 1 cycle from input fire to out_valid.
  - ONE: in_ready=1, out_valid=1.
    - Input and output fire together: MAIN <= input, stay ONE.
    - Output fire only: -> EMPTY.
    - Input fire only: SKID <= input -> FULL.
  - FULL: in_ready=0, out_valid=1.
    - Output fire: MAIN <= SKID -> ONE.
    - in_valid is ignored.
- Ordering: bundles leave in acceptance order and are never duplicated.
- Flush:
  - Priority is below rst and above all else.
  - Next cycle: EMPTY, out_valid=0, out_lane_v=0.
  - Any input or output fire in the flush cycle is discarded; the output side is still considered consumed.
  - Payload registers may retain stale data but must be masked by lane_v=0.
- Invalid lanes in a valid bundle: payload is passed through unchanged and is don't-care to downstream.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready and holds at 2^CNT_W-1.
  - Cleared only by rst, not by flush.
- Payload is stored bit-exact; the block performs no arithmetic on imm.
- in_ready is a pure function of registered state (FULL -> 0); no dependence on out_ready in the same cycle.

Decomposition:
- riscv_pkg holds:
  - Opcode constants OP_LUI=5'b01101, OP_AUIPC=5'b00101, OP_IMM=5'b00100, OP_LOAD=5'b00000, OP_STORE=5'b01000, OP_JALR=5'b11001, OP_JAL=5'b11011, OP_BRANCH=5'b11000.
  - The dec_lane_t packed struct (89 bits) and the LANES and XLEN defaults.
- Sub-module lane_bundle_reg: one LANES-wide bundle register with load enable and lane_v clear. Instantiated twice, once as MAIN and once as SKID.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then in_valid=0.
  - Required: in_ready=1, out_valid=0, occupancy=0, stall_cnt=0 throughout.
- Single pass-through:
  - Stimulus: lane0 pc=0x100, imm=0xFFFFF800, op_code=OP_IMM, in_lane_v=2'b01, out_ready=1.
  - Required: out_valid=1 exactly one cycle later with identical payload, then occupancy returns to 0.
- Backpressure fill:
  - Stimulus: out_ready=0; offer bundles A (pc=0x200) and B (pc=0x208) back-to-back.
  - Required: occupancy=2, in_ready=0, bundle C held off. Release out_ready -> A, then B, then C out in order, no loss; stall_cnt equals the stalled cycle count.
- Flush when FULL:
  - Stimulus: assert flush while occupancy=2 and in_valid=1.
  - Required: next cycle occupancy=0, out_valid=0, out_lane_v=0; the offered bundle never appears.
- Bubble and counter saturation:
  - Stimulus 1: in_lane_v=0 with in_valid=1. Required: accepted (in_ready=1), occupancy unchanged.
  - Stimulus 2: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt=15.
- Continuous streaming:
  - Stimulus: in_valid=1 and out_ready=1 every cycle for 50 bundles, pc incrementing by 8.
  - Required: one bundle out per cycle after 1-cycle latency, occupancy stays 1.
